// File: rtl/settings_ctrl.sv
// rtl/settings_ctrl.sv - game settings editor: pending/committed mode, level, speed with edit FSM
module settings_ctrl #(
  parameter int N_MODES   = 4,
  parameter int N_LEVELS  = 4,
  parameter int N_SPEEDS  = 4,
  parameter int DEF_MODE  = 0,
  parameter int DEF_LEVEL = 0,
  parameter int DEF_SPEED = 0,
  localparam int MW = (N_MODES  > 2) ? $clog2(N_MODES)  : 1,
  localparam int LW = (N_LEVELS > 2) ? $clog2(N_LEVELS) : 1,
  localparam int SW = (N_SPEEDS > 2) ? $clog2(N_SPEEDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_btn,
  input  logic          inc_btn,
  input  logic          dec_btn,
  input  logic          commit,
  input  logic          cancel,
  input  logic          game_busy,
  output logic [MW-1:0] mode,
  output logic [LW-1:0] level,
  output logic [SW-1:0] speed,
  output logic [MW-1:0] pend_mode,
  output logic [LW-1:0] pend_level,
  output logic [SW-1:0] pend_speed,
  output logic [1:0]    edit_field,
  output logic          editing,
  output logic          dirty,
  output logic          cfg_valid,
  output logic          busy_err
);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_APPLY} state_t;

  localparam logic [MW-1:0] M_MAX = MW'(N_MODES - 1);
  localparam logic [LW-1:0] L_MAX = LW'(N_LEVELS - 1);
  localparam logic [SW-1:0] S_MAX = SW'(N_SPEEDS - 1);
  localparam logic [MW-1:0] M_DEF = MW'(DEF_MODE);
  localparam logic [LW-1:0] L_DEF = LW'(DEF_LEVEL);
  localparam logic [SW-1:0] S_DEF = SW'(DEF_SPEED);

  state_t        state_q, state_d;
  logic          sel_prev_q, inc_prev_q, dec_prev_q;
  logic          sel_e, inc_e, dec_e;
  logic [MW-1:0] mode_q, mode_d, pmode_q, pmode_d, pmode_up, pmode_dn;
  logic [LW-1:0] level_q, level_d, plevel_q, plevel_d, plevel_up, plevel_dn;
  logic [SW-1:0] speed_q, speed_d, pspeed_q, pspeed_d, pspeed_up, pspeed_dn;
  logic [1:0]    field_q, field_d;
  logic          cfg_valid_q, cfg_valid_d;
  logic          busy_err_q, busy_err_d;

  assign sel_e = sel_btn & ~sel_prev_q;
  assign inc_e = inc_btn & ~inc_prev_q;
  assign dec_e = dec_btn & ~dec_prev_q;

  // Wrap at the field's own N so non-power-of-2 ranges never overflow
  assign pmode_up  = (pmode_q  == M_MAX) ? '0 : pmode_q  + MW'(1);
  assign pmode_dn  = (pmode_q  == '0)    ? M_MAX : pmode_q  - MW'(1);
  assign plevel_up = (plevel_q == L_MAX) ? '0 : plevel_q + LW'(1);
  assign plevel_dn = (plevel_q == '0)    ? L_MAX : plevel_q - LW'(1);
  assign pspeed_up = (pspeed_q == S_MAX) ? '0 : pspeed_q + SW'(1);
  assign pspeed_dn = (pspeed_q == '0)    ? S_MAX : pspeed_q - SW'(1);

  // Next-state and datapath decisions for the IDLE/EDIT/APPLY controller
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    level_d     = level_q;
    speed_d     = speed_q;
    pmode_d     = pmode_q;
    plevel_d    = plevel_q;
    pspeed_d    = pspeed_q;
    field_d     = field_q;
    cfg_valid_d = 1'b0;
    busy_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_e) begin
          if (game_busy) begin
            busy_err_d = 1'b1;
          end else begin
            state_d  = S_EDIT;
            pmode_d  = mode_q;
            plevel_d = level_q;
            pspeed_d = speed_q;
            field_d  = 2'd0;
          end
        end
      end
      S_EDIT: begin
        if (cancel) begin
          state_d  = S_IDLE;
          pmode_d  = mode_q;
          plevel_d = level_q;
          pspeed_d = speed_q;
        end else if (commit) begin
          // Button edges in a commit cycle are dropped, busy or not
          if (game_busy) busy_err_d = 1'b1;
          else           state_d    = S_APPLY;
        end else begin
          // inc/dec act on the field selected before any sel advance this cycle
          if (inc_e != dec_e) begin
            case (field_q)
              2'd0:    pmode_d  = inc_e ? pmode_up  : pmode_dn;
              2'd1:    plevel_d = inc_e ? plevel_up : plevel_dn;
              2'd2:    pspeed_d = inc_e ? pspeed_up : pspeed_dn;
              default: ;
            endcase
          end
          if (sel_e) field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
        end
      end
      S_APPLY: begin
        mode_d      = pmode_q;
        level_d     = plevel_q;
        speed_d     = pspeed_q;
        cfg_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, settings and button history; history resets high so held buttons give no edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_prev_q  <= 1'b1;
      inc_prev_q  <= 1'b1;
      dec_prev_q  <= 1'b1;
      mode_q      <= M_DEF;
      level_q     <= L_DEF;
      speed_q     <= S_DEF;
      pmode_q     <= M_DEF;
      plevel_q    <= L_DEF;
      pspeed_q    <= S_DEF;
      field_q     <= 2'd0;
      cfg_valid_q <= 1'b0;
      busy_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_prev_q  <= sel_btn;
      inc_prev_q  <= inc_btn;
      dec_prev_q  <= dec_btn;
      mode_q      <= mode_d;
      level_q     <= level_d;
      speed_q     <= speed_d;
      pmode_q     <= pmode_d;
      plevel_q    <= plevel_d;
      pspeed_q    <= pspeed_d;
      field_q     <= field_d;
      cfg_valid_q <= cfg_valid_d;
      busy_err_q  <= busy_err_d;
    end
  end

  assign mode       = mode_q;
  assign level      = level_q;
  assign speed      = speed_q;
  assign pend_mode  = pmode_q;
  assign pend_level = plevel_q;
  assign pend_speed = pspeed_q;
  assign edit_field = field_q;
  assign editing    = (state_q == S_EDIT);
  assign dirty      = editing && ((pmode_q != mode_q) || (plevel_q != level_q) ||
                                  (pspeed_q != speed_q));
  assign cfg_valid  = cfg_valid_q;
  assign busy_err   = busy_err_q;

endmodule

// File: tb/tb_settings_ctrl.sv
// tb/tb_settings_ctrl.sv - directed self-checking bench for settings_ctrl
module tb_settings_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_btn, inc_btn, dec_btn, commit, cancel, game_busy;
  logic [1:0] mode, level, speed, pend_mode, pend_level, pend_speed, edit_field;
  logic       editing, dirty, cfg_valid, busy_err;
  int         n_cmp = 0;
  int         n_err = 0;

  settings_ctrl #(
    .N_MODES(4), .N_LEVELS(3), .N_SPEEDS(4),
    .DEF_MODE(0), .DEF_LEVEL(0), .DEF_SPEED(0)
  ) dut (
    .clk(clk), .rst(rst),
    .sel_btn(sel_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .commit(commit), .cancel(cancel), .game_busy(game_busy),
    .mode(mode), .level(level), .speed(speed),
    .pend_mode(pend_mode), .pend_level(pend_level), .pend_speed(pend_speed),
    .edit_field(edit_field), .editing(editing), .dirty(dirty),
    .cfg_valid(cfg_valid), .busy_err(busy_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_sel();
    sel_btn = 1'b1; step(); sel_btn = 1'b0; step();
  endtask

  task automatic press_inc();
    inc_btn = 1'b1; step(); inc_btn = 1'b0; step();
  endtask

  task automatic press_dec();
    dec_btn = 1'b1; step(); dec_btn = 1'b0; step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sel_btn = 0; inc_btn = 0; dec_btn = 0; commit = 0; cancel = 0; game_busy = 0;
    step(); step();
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL reset_mode got %0d exp 0", mode); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL reset_level got %0d exp 0", level); end
    n_cmp++; if (pend_speed !== 2'd0) begin n_err++; $display("FAIL reset_pend_speed got %0d exp 0", pend_speed); end
    n_cmp++; if (edit_field !== 2'd0) begin n_err++; $display("FAIL reset_edit_field got %0d exp 0", edit_field); end
    n_cmp++; if ({editing, dirty, cfg_valid, busy_err} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b exp 0000", {editing, dirty, cfg_valid, busy_err});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_commit();
    press_sel();
    n_cmp++; if (editing !== 1'b1) begin n_err++; $display("FAIL basic_editing got %0d exp 1", editing); end
    press_inc();
    press_inc();
    n_cmp++; if (edit_field !== 2'd0) begin n_err++; $display("FAIL basic_edit_field got %0d exp 0", edit_field); end
    n_cmp++; if (pend_mode !== 2'd2) begin n_err++; $display("FAIL basic_pend_mode got %0d exp 2", pend_mode); end
    n_cmp++; if (dirty !== 1'b1) begin n_err++; $display("FAIL basic_dirty got %0d exp 1", dirty); end
    commit = 1'b1; step(); commit = 1'b0;
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL basic_mode_early got %0d exp 0", mode); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL basic_cfg_early got %0d exp 0", cfg_valid); end
    step();
    n_cmp++; if (mode !== 2'd2) begin n_err++; $display("FAIL basic_mode got %0d exp 2", mode); end
    n_cmp++; if (cfg_valid !== 1'b1) begin n_err++; $display("FAIL basic_cfg_valid got %0d exp 1", cfg_valid); end
    step();
    n_cmp++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL basic_cfg_one_cycle got %0d exp 0", cfg_valid); end
    n_cmp++; if ({editing, dirty} !== 2'b00) begin n_err++; $display("FAIL basic_idle got %b exp 00", {editing, dirty}); end
  endtask

  task automatic test_wrap_level();
    press_sel();
    press_sel();
    n_cmp++; if (edit_field !== 2'd1) begin n_err++; $display("FAIL wrap_edit_field got %0d exp 1", edit_field); end
    press_dec();
    n_cmp++; if (pend_level !== 2'd2) begin n_err++; $display("FAIL wrap_dec got %0d exp 2", pend_level); end
    press_inc();
    n_cmp++; if (pend_level !== 2'd0) begin n_err++; $display("FAIL wrap_inc_top got %0d exp 0", pend_level); end
    press_inc();
    n_cmp++; if (pend_level !== 2'd1) begin n_err++; $display("FAIL wrap_inc got %0d exp 1", pend_level); end
    cancel = 1'b1; step(); cancel = 1'b0; step();
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL wrap_cancel_editing got %0d exp 0", editing); end
    n_cmp++; if (pend_level !== 2'd0) begin n_err++; $display("FAIL wrap_cancel_pend got %0d exp 0", pend_level); end
    n_cmp++; if (level !== 2'd0) begin n_err++; $display("FAIL wrap_level got %0d exp 0", level); end
  endtask

  task automatic test_busy_commit();
    game_busy = 1'b1;
    sel_btn = 1'b1; step(); sel_btn = 1'b0;
    n_cmp++; if (busy_err !== 1'b1) begin n_err++; $display("FAIL busy_idle_err got %0d exp 1", busy_err); end
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL busy_idle_editing got %0d exp 0", editing); end
    step();
    n_cmp++; if (busy_err !== 1'b0) begin n_err++; $display("FAIL busy_idle_err_pulse got %0d exp 0", busy_err); end
    game_busy = 1'b0;
    press_sel();
    press_inc();
    n_cmp++; if (pend_mode !== 2'd3) begin n_err++; $display("FAIL busy_pend_mode got %0d exp 3", pend_mode); end
    game_busy = 1'b1;
    commit = 1'b1; step(); commit = 1'b0;
    n_cmp++; if (busy_err !== 1'b1) begin n_err++; $display("FAIL busy_commit_err got %0d exp 1", busy_err); end
    n_cmp++; if (editing !== 1'b1) begin n_err++; $display("FAIL busy_commit_editing got %0d exp 1", editing); end
    n_cmp++; if (mode !== 2'd2) begin n_err++; $display("FAIL busy_commit_mode got %0d exp 2", mode); end
    step();
    n_cmp++; if (busy_err !== 1'b0) begin n_err++; $display("FAIL busy_commit_pulse got %0d exp 0", busy_err); end
    n_cmp++; if (pend_mode !== 2'd3) begin n_err++; $display("FAIL busy_commit_pend got %0d exp 3", pend_mode); end
    game_busy = 1'b0;
    commit = 1'b1; step(); commit = 1'b0;
    step();
    n_cmp++; if (mode !== 2'd3) begin n_err++; $display("FAIL busy_retry_mode got %0d exp 3", mode); end
    n_cmp++; if ({cfg_valid, busy_err} !== 2'b10) begin
      n_err++; $display("FAIL busy_retry_flags got %b exp 10", {cfg_valid, busy_err});
    end
    step();
  endtask

  task automatic test_cancel_priority();
    press_sel();
    press_sel();
    press_sel();
    n_cmp++; if (edit_field !== 2'd2) begin n_err++; $display("FAIL cancel_edit_field got %0d exp 2", edit_field); end
    press_dec();
    n_cmp++; if (pend_speed !== 2'd3) begin n_err++; $display("FAIL cancel_pend_before got %0d exp 3", pend_speed); end
    commit = 1'b1; cancel = 1'b1; step(); commit = 1'b0; cancel = 1'b0;
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL cancel_editing got %0d exp 0", editing); end
    n_cmp++; if (pend_speed !== 2'd0) begin n_err++; $display("FAIL cancel_pend got %0d exp 0", pend_speed); end
    step();
    n_cmp++; if (speed !== 2'd0) begin n_err++; $display("FAIL cancel_speed got %0d exp 0", speed); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL cancel_cfg got %0d exp 0", cfg_valid); end
  endtask

  task automatic test_simultaneous();
    press_sel();
    inc_btn = 1'b1; dec_btn = 1'b1; step(); inc_btn = 1'b0; dec_btn = 1'b0; step();
    n_cmp++; if (pend_mode !== 2'd3) begin n_err++; $display("FAIL simul_inc_dec got %0d exp 3", pend_mode); end
    n_cmp++; if (dirty !== 1'b0) begin n_err++; $display("FAIL simul_dirty got %0d exp 0", dirty); end
    press_sel();
    inc_btn = 1'b1;
    repeat (10) step();
    inc_btn = 1'b0; step();
    n_cmp++; if (pend_level !== 2'd1) begin n_err++; $display("FAIL held_inc got %0d exp 1", pend_level); end
    sel_btn = 1'b1; inc_btn = 1'b1; step(); sel_btn = 1'b0; inc_btn = 1'b0; step();
    n_cmp++; if (pend_level !== 2'd2) begin n_err++; $display("FAIL sel_inc_level got %0d exp 2", pend_level); end
    n_cmp++; if (edit_field !== 2'd2) begin n_err++; $display("FAIL sel_inc_field got %0d exp 2", edit_field); end
    n_cmp++; if (pend_speed !== 2'd0) begin n_err++; $display("FAIL sel_inc_speed got %0d exp 0", pend_speed); end
    cancel = 1'b1; step(); cancel = 1'b0; step();
  endtask

  task automatic test_reset_apply();
    press_sel();
    press_dec();
    n_cmp++; if (pend_mode !== 2'd2) begin n_err++; $display("FAIL rstap_pend got %0d exp 2", pend_mode); end
    commit = 1'b1; step(); commit = 1'b0;
    rst = 1'b1; sel_btn = 1'b1;
    #1;
    n_cmp++; if (mode !== 2'd0) begin n_err++; $display("FAIL rstap_mode got %0d exp 0", mode); end
    n_cmp++; if (pend_mode !== 2'd0) begin n_err++; $display("FAIL rstap_pend_mode got %0d exp 0", pend_mode); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL rstap_cfg_at_once got %0d exp 0", cfg_valid); end
    step(); step();
    n_cmp++; if ({cfg_valid, mode} !== 3'b000) begin
      n_err++; $display("FAIL rstap_hold got %b exp 000", {cfg_valid, mode});
    end
    rst = 1'b0;
    step(); step();
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL rstap_held_sel got %0d exp 0", editing); end
    n_cmp++; if ({cfg_valid, busy_err} !== 2'b00) begin
      n_err++; $display("FAIL rstap_flags got %b exp 00", {cfg_valid, busy_err});
    end
    sel_btn = 1'b0; step();
    n_cmp++; if (editing !== 1'b0) begin n_err++; $display("FAIL rstap_release got %0d exp 0", editing); end
    press_sel();
    n_cmp++; if (editing !== 1'b1) begin n_err++; $display("FAIL rstap_new_edit got %0d exp 1", editing); end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_wrap_level();
    test_busy_commit();
    test_cancel_priority();
    test_simultaneous();
    test_reset_apply();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
